// File: rtl/alu_issue.sv
// alu_issue: single-issue ALU sequencer with an 8x16 register file and flag register.
// Optional `ALU_ISSUE_R0_ZERO_EN makes R0 a constant zero by discarding writes to it.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  instr_opcode,
    input  logic [7:0]  instr_ctrl,
    input  logic [2:0]  instr_rd,
    input  logic [2:0]  instr_rs1,
    input  logic [2:0]  instr_rs2,
    input  logic [15:0] instr_imm,
    input  logic        instr_use_imm,
    input  logic        instr_wr_en,
    input  logic        instr_flags_en,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_ctrl,
    input  logic [15:0] alu_r,
    input  logic [6:0]  alu_flags,
    output logic [6:0]  cpsr,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t      state;
    logic [15:0] regs [8];
    logic [7:0]  op_q, ctrl_q;
    logic [2:0]  rd_q, rs1_q, rs2_q;
    logic [15:0] imm_q, res_q;
    logic        use_imm_q, wr_en_q, flags_en_q;
    logic [6:0]  flg_q;
    logic        wr_ok;
`ifdef ALU_ISSUE_R0_ZERO_EN
    // R0 is never written, so its reset value keeps every read path at zero
    assign wr_ok = wr_en_q && rd_q != 3'd0;
`else
    assign wr_ok = wr_en_q;
`endif
    assign instr_ready = state == IDLE && !flush;
    assign dbg_data    = regs[dbg_addr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            cpsr       <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_opcode <= '0;
            alu_ctrl   <= '0;
            op_q       <= '0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            flags_en_q <= 1'b0;
            res_q      <= '0;
            flg_q      <= '0;
        end else if (flush) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (instr_valid) begin
                    op_q       <= instr_opcode;
                    ctrl_q     <= instr_ctrl;
                    rd_q       <= instr_rd;
                    rs1_q      <= instr_rs1;
                    rs2_q      <= instr_rs2;
                    imm_q      <= instr_imm;
                    use_imm_q  <= instr_use_imm;
                    wr_en_q    <= instr_wr_en;
                    flags_en_q <= instr_flags_en;
                    state      <= READ;
                end
                READ: begin
                    alu_x      <= regs[rs1_q];
                    alu_y      <= use_imm_q ? imm_q : regs[rs2_q];
                    alu_opcode <= op_q;
                    alu_ctrl   <= ctrl_q;
                    state      <= EXEC;
                end
                EXEC: begin
                    res_q <= alu_r;
                    flg_q <= alu_flags;
                    state <= WB;
                end
                WB: begin
                    if (wr_ok) regs[rd_q] <= res_q;
                    if (flags_en_q) cpsr <= flg_q;
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= res_q;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed scenarios plus randomized traffic checked each cycle against a
// transaction-level model; honours `ALU_ISSUE_R0_ZERO_EN like the design.
module tb_alu_issue;
    logic clk = 0, rst = 0, flush = 0, instr_valid = 0, instr_ready;
    logic [7:0] instr_opcode = 0, instr_ctrl = 0, alu_opcode, alu_ctrl;
    logic [2:0] instr_rd = 0, instr_rs1 = 0, instr_rs2 = 0, wb_rd, dbg_addr = 0;
    logic [15:0] instr_imm = 0, alu_x, alu_y, alu_r, wb_data, dbg_data;
    logic instr_use_imm = 0, instr_wr_en = 0, instr_flags_en = 0, wb_valid;
    logic [6:0] alu_flags, cpsr;
    int n_checks = 0, n_fail = 0, cyc = 0;

    alu_issue dut (.clk(clk), .rst(rst), .flush(flush), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_ctrl(instr_ctrl),
        .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .instr_use_imm(instr_use_imm), .instr_wr_en(instr_wr_en), .instr_flags_en(instr_flags_en),
        .alu_x(alu_x), .alu_y(alu_y), .alu_opcode(alu_opcode), .alu_ctrl(alu_ctrl), .alu_r(alu_r),
        .alu_flags(alu_flags), .cpsr(cpsr), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stand-in: opcode bit 0 selects subtract, otherwise add
    function automatic logic [22:0] alu_fn(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = op[0] ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
        return {3'b000, s[16], s[15:0] == 16'h0, s[15], 1'b0, s[15:0]};
    endfunction
    always_comb {alu_flags, alu_r} = alu_fn(alu_opcode, alu_x, alu_y);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // transaction-level model: one instruction in flight, retiring three edges after acceptance
    logic [15:0] m_regs [8];
    logic [6:0] m_cpsr;
    logic [15:0] m_ax, m_ay, m_wbd, q_imm;
    logic [7:0] m_aop, m_actl, q_op, q_ctrl;
    logic [2:0] m_wbrd, q_rd, q_rs1, q_rs2;
    logic [22:0] m_res;
    logic m_wbv, q_use, q_wr, q_fl;
    bit busy = 0;
    int age = 0;

    function automatic logic [15:0] rdm(input logic [2:0] a);
`ifdef ALU_ISSUE_R0_ZERO_EN
        if (a == 3'd0) return 16'h0;
`endif
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0; age = 0;
            for (int i = 0; i < 8; i++) m_regs[i] = 0;
            m_cpsr = 0; m_wbv = 0; m_wbrd = 0; m_wbd = 0;
            m_ax = 0; m_ay = 0; m_aop = 0; m_actl = 0;
        end else begin
            m_wbv = 0;
            if (flush) busy = 0;
            else if (busy) begin
                age++;
                if (age == 1) begin
                    m_ax = rdm(q_rs1); m_ay = q_use ? q_imm : rdm(q_rs2);
                    m_aop = q_op; m_actl = q_ctrl;
                end else if (age == 2) m_res = alu_fn(m_aop, m_ax, m_ay);
                else begin
`ifdef ALU_ISSUE_R0_ZERO_EN
                    if (q_wr && q_rd != 0) m_regs[q_rd] = m_res[15:0];
`else
                    if (q_wr) m_regs[q_rd] = m_res[15:0];
`endif
                    if (q_fl) m_cpsr = m_res[22:16];
                    m_wbv = 1; m_wbrd = q_rd; m_wbd = m_res[15:0]; busy = 0;
                end
            end else if (instr_valid) begin
                busy = 1; age = 0;
                q_op = instr_opcode; q_ctrl = instr_ctrl; q_rd = instr_rd; q_rs1 = instr_rs1;
                q_rs2 = instr_rs2; q_imm = instr_imm; q_use = instr_use_imm;
                q_wr = instr_wr_en; q_fl = instr_flags_en;
            end
        end
    end

    always @(negedge clk) begin
        chk("instr_ready", instr_ready, !busy && !flush);
        chk("wb_valid", wb_valid, m_wbv);
        if (m_wbv) begin
            chk("wb_rd", wb_rd, m_wbrd);
            chk("wb_data", wb_data, m_wbd);
        end
        chk("cpsr", cpsr, m_cpsr);
        chk("dbg_data", dbg_data, rdm(dbg_addr));
        chk("alu_x", alu_x, m_ax);
        chk("alu_y", alu_y, m_ay);
        chk("alu_opcode", alu_opcode, m_aop);
        chk("alu_ctrl", alu_ctrl, m_actl);
    end

    task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [15:0] imm, input logic wr, input logic fl, output int acc);
        int n = 0;
        @(negedge clk);
        instr_valid = 1; instr_opcode = op; instr_ctrl = op ^ 8'h5a; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs1 + 3'd1; instr_imm = imm; instr_use_imm = 1;
        instr_wr_en = wr; instr_flags_en = fl;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        if (!instr_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        acc = cyc;
        #1 instr_valid = 0;
    endtask

    task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string name);
        dbg_addr = a;
        #1 chk(name, dbg_data, exp);
    endtask

    int a1, a2;
    initial begin
        #1 rst = 1;
        #1 chk("rst_cpsr", cpsr, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_alu_x", alu_x, 0);
        for (int i = 0; i < 8; i++) peek(i[2:0], 16'h0, "rst_dbg");
        repeat (2) @(negedge clk);
        rst = 0;
        #1 chk("ready_after_rst", instr_ready, 1);
        issue(8'h00, 3'd1, 3'd0, 16'd5, 1, 0, a1);
        repeat (3) @(posedge clk);
        #1 peek(3'd1, 16'd5, "load_r1");
        issue(8'h00, 3'd2, 3'd1, 16'd3, 1, 1, a1);
        repeat (2) @(posedge clk);
        #1 chk("add_wb_early", wb_valid, 0);
        @(posedge clk);
        #1 chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_rd", wb_rd, 2);
        chk("add_wb_data", wb_data, 16'd8);
        peek(3'd2, 16'd8, "add_r2");
        issue(8'h00, 3'd3, 3'd2, 16'd1, 1, 1, a1);
        issue(8'h00, 3'd4, 3'd3, 16'd1, 1, 1, a2);
        chk("b2b_accept_gap", a2 - a1, 4);
        repeat (3) @(posedge clk);
        #1 peek(3'd4, 16'd10, "b2b_raw_r4");
        issue(8'h01, 3'd6, 3'd4, 16'd10, 0, 1, a1);
        repeat (3) @(posedge clk);
        #1 chk("cmp_cpsr", cpsr, 7'b0000100);
        peek(3'd6, 16'h0, "cmp_no_write");
        issue(8'h00, 3'd5, 3'd4, 16'd100, 1, 1, a1);
        @(posedge clk);
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        #1 chk("flush_ready", instr_ready, 1);
        repeat (3) begin
            @(posedge clk);
            #1 chk("flush_no_wb", wb_valid, 0);
        end
        peek(3'd5, 16'h0, "flush_no_write");
        chk("flush_cpsr", cpsr, 7'b0000100);
        issue(8'h00, 3'd0, 3'd0, 16'h1234, 1, 0, a1);
        repeat (3) @(posedge clk);
        #1 chk("r0_wb_data", wb_data, 16'h1234);
`ifdef ALU_ISSUE_R0_ZERO_EN
        peek(3'd0, 16'h0000, "r0_read");
`else
        peek(3'd0, 16'h1234, "r0_read");
`endif
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            instr_valid = 1'($urandom_range(0, 1));
            instr_opcode = 8'($urandom); instr_ctrl = 8'($urandom);
            instr_rd = 3'($urandom); instr_rs1 = 3'($urandom); instr_rs2 = 3'($urandom);
            instr_imm = 16'($urandom); instr_use_imm = 1'($urandom_range(0, 1));
            instr_wr_en = 1'($urandom_range(0, 1)); instr_flags_en = 1'($urandom_range(0, 1));
            flush = $urandom_range(0, 15) == 0;
            dbg_addr = 3'($urandom);
            if (i == 200) #2 rst = 1;
            if (i == 202) rst = 0;
        end
        @(negedge clk);
        instr_valid = 0; flush = 0;
        repeat (6) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
